// File: rtl/conv_pkg.sv
// Shared constants for the 2x2 convolution blocks.
// Window lane order and packed window width helper.
package conv_pkg;

  localparam int DATA_W_DEF = 8;

  localparam int LANE_TL = 3;
  localparam int LANE_TR = 2;
  localparam int LANE_BL = 1;
  localparam int LANE_BR = 0;

  function automatic int win_w(input int dw);
    return 4 * dw;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One-line pixel buffer, single read/write port at index idx_i.
// Read is combinational; write lands on the rising edge.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[idx_i];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv_win_gen_2x2.sv
// Raster stream to stride-1 2x2 window generator.
// Optional win_last output enabled by CONV_WIN_LAST_EN.
module conv_win_gen_2x2
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [win_w(DATA_W)-1:0]  image,
`ifdef CONV_WIN_LAST_EN
  output logic                      win_last,
`endif
  output logic                      frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int IW = win_w(DATA_W);
  localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] above_prev_q;
  logic [DATA_W-1:0] above;
  logic [IW-1:0]     image_q, image_d;
  logic              win_valid_q;
  logic              frame_done_q;
  logic              acc;
  logic              emit;
  logic              col_end;
  logic              row_end;
`ifdef CONV_WIN_LAST_EN
  logic              win_last_q;
`endif

  conv_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .AW     (CW)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (acc),
    .idx_i   (col_q),
    .wdata_i (s_data),
    .rdata_o (above)
  );

  always_comb begin
    s_ready = !win_valid_q || win_ready;
    acc     = s_valid && s_ready;
    col_end = (col_q == COL_END);
    row_end = (row_q == ROW_END);
    emit    = acc && (row_q != '0) && (col_q != '0);
    col_d   = col_end ? '0 : col_q + 1'b1;
    row_d   = row_q;
    if (col_end) begin
      row_d = row_end ? '0 : row_q + 1'b1;
    end
    image_d = '0;
    image_d[LANE_TL*DATA_W +: DATA_W] = above_prev_q;
    image_d[LANE_TR*DATA_W +: DATA_W] = above;
    image_d[LANE_BL*DATA_W +: DATA_W] = prev_q;
    image_d[LANE_BR*DATA_W +: DATA_W] = s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      prev_q       <= '0;
      above_prev_q <= '0;
      image_q      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef CONV_WIN_LAST_EN
      win_last_q   <= 1'b0;
`endif
    end else begin
      if (acc) begin
        col_q        <= col_d;
        row_q        <= row_d;
        prev_q       <= s_data;
        above_prev_q <= above;
      end
      // emit implies s_ready, so a stalled window is never overwritten
      if (emit) begin
        win_valid_q <= 1'b1;
        image_q     <= image_d;
`ifdef CONV_WIN_LAST_EN
        win_last_q  <= row_end && col_end;
`endif
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
`ifdef CONV_WIN_LAST_EN
        win_last_q  <= 1'b0;
`endif
      end
      frame_done_q <= acc && row_end && col_end;
    end
  end

  assign win_valid  = win_valid_q;
  assign image      = image_q;
  assign frame_done = frame_done_q;
`ifdef CONV_WIN_LAST_EN
  assign win_last   = win_last_q;
`endif

endmodule
